// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO divide controller.
package hilo_div_pkg;

   localparam int unsigned HILO_WIDTH = 32;
   localparam logic [HILO_WIDTH-1:0] HILO_DIVZERO_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StDone
   } hilo_state_e;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Handshake between the HI/LO controller (master) and the iterative divide core (slave).
interface hilo_div_ctrl_if;
   import hilo_div_pkg::*;

   logic [HILO_WIDTH-1:0] div_dividend;
   logic [HILO_WIDTH-1:0] div_divisor;
   logic                  div_start;
   logic [HILO_WIDTH-1:0] div_q;
   logic [HILO_WIDTH-1:0] div_r;
   logic                  div_busy;

   modport master (
      output div_dividend, div_divisor, div_start,
      input  div_q, div_r, div_busy
   );

   modport slave (
      input  div_dividend, div_divisor, div_start,
      output div_q, div_r, div_busy
   );

endinterface

// File: rtl/div_sign_fixup.sv
// Signed-divide pre/post processing: operand magnitudes and sign flags going in,
// conditional negation of quotient/remainder coming out.
module div_sign_fixup
   import hilo_div_pkg::*;
(
   input  logic                  is_signed,
   input  logic [HILO_WIDTH-1:0] rs_data,
   input  logic [HILO_WIDTH-1:0] rt_data,
   output logic [HILO_WIDTH-1:0] rs_mag,
   output logic [HILO_WIDTH-1:0] rt_mag,
   output logic                  q_neg_new,
   output logic                  r_neg_new,
   input  logic                  q_neg,
   input  logic                  r_neg,
   input  logic [HILO_WIDTH-1:0] quot,
   input  logic [HILO_WIDTH-1:0] rem,
   output logic [HILO_WIDTH-1:0] lo_fix,
   output logic [HILO_WIDTH-1:0] hi_fix
);

   logic rs_sign;
   logic rt_sign;

   assign rs_sign = is_signed & rs_data[HILO_WIDTH-1];
   assign rt_sign = is_signed & rt_data[HILO_WIDTH-1];

   // Two's-complement negate wraps, so |0x8000_0000| stays 0x8000_0000.
   assign rs_mag = rs_sign ? (~rs_data + 1'b1) : rs_data;
   assign rt_mag = rt_sign ? (~rt_data + 1'b1) : rt_data;

   assign q_neg_new = rs_sign ^ rt_sign;
   assign r_neg_new = rs_sign;

   assign lo_fix = q_neg ? (~quot + 1'b1) : quot;
   assign hi_fix = r_neg ? (~rem + 1'b1) : rem;

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and divide sequencer: launches the divide core, waits on busy,
// sign-corrects the result and stalls the pipeline while a divide is in flight.
module hilo_div_ctrl
   import hilo_div_pkg::*;
#(
   parameter int unsigned           WIDTH      = HILO_WIDTH,
   parameter logic [HILO_WIDTH-1:0] DIVZERO_LO = HILO_DIVZERO_LO
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_div,
   input  logic             op_divu,
   input  logic             op_mthi,
   input  logic             op_mtlo,
   input  logic             op_mfhi,
   input  logic             op_mflo,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             stall,
   hilo_div_ctrl_if.master  div
);

   hilo_state_e     state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
   logic             start_q, start_d;
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;

   logic [WIDTH-1:0] rs_mag, rt_mag, lo_fix, hi_fix;
   logic             q_neg_new, r_neg_new;
   logic             div_req;

   // MF* only matter through the stall they see in busy states; their read is in the CPU.
   logic unused_mf;
   assign unused_mf = op_mfhi | op_mflo;

   assign div_req = op_div | op_divu;

   div_sign_fixup u_sign_fixup (
      .is_signed (op_div),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .rs_mag    (rs_mag),
      .rt_mag    (rt_mag),
      .q_neg_new (q_neg_new),
      .r_neg_new (r_neg_new),
      .q_neg     (q_neg_q),
      .r_neg     (r_neg_q),
      .quot      (div.div_q),
      .rem       (div.div_r),
      .lo_fix    (lo_fix),
      .hi_fix    (hi_fix)
   );

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      start_d    = start_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      stall      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (div_req) begin
               stall = 1'b1;
               if (rt_data != '0) begin
                  dividend_d = rs_mag;
                  divisor_d  = rt_mag;
                  q_neg_d    = q_neg_new;
                  r_neg_d    = r_neg_new;
                  start_d    = 1'b1;
                  state_d    = StLaunch;
               end else begin
                  hi_d    = rs_data;
                  lo_d    = DIVZERO_LO;
                  state_d = StDone;
               end
            end else if (op_mthi) begin
               hi_d = rs_data;
            end else if (op_mtlo) begin
               lo_d = rs_data;
            end
         end
         StLaunch: begin
            stall = 1'b1;
            if (div.div_busy) begin
               start_d = 1'b0;
               state_d = StWait;
            end
         end
         StWait: begin
            stall = 1'b1;
            if (!div.div_busy) begin
               lo_d    = lo_fix;
               hi_d    = hi_fix;
               state_d = StDone;
            end
         end
         // The held divide retires here; any op is ignored so it is not relaunched.
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         hi_q       <= '0;
         lo_q       <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         start_q    <= 1'b0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         start_q    <= start_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
      end
   end

   assign hi               = hi_q;
   assign lo               = lo_q;
   assign div.div_dividend = dividend_q;
   assign div.div_divisor  = divisor_q;
   assign div.div_start    = start_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a negedge divide-core model.
module tb_hilo_div_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo;
   logic [31:0] rs_data, rt_data;
   logic [31:0] hi, lo;
   logic        stall;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   logic start_prev = 1'b0;
   logic [31:0] hi_exp = '0, lo_exp = '0;

   hilo_div_ctrl_if div_bus ();

   hilo_div_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .op_div  (op_div),
      .op_divu (op_divu),
      .op_mthi (op_mthi),
      .op_mtlo (op_mtlo),
      .op_mfhi (op_mfhi),
      .op_mflo (op_mflo),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .hi      (hi),
      .lo      (lo),
      .stall   (stall),
      .div     (div_bus)
   );

   always #5 clk = ~clk;

   // Divide core model: one load negedge, then 32 iteration negedges.
   logic [31:0] core_a, core_b;
   int          core_cnt;
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         div_bus.div_busy <= 1'b0;
         div_bus.div_q    <= '0;
         div_bus.div_r    <= '0;
         core_cnt         <= 0;
      end else if (!div_bus.div_busy) begin
         if (div_bus.div_start) begin
            core_a           <= div_bus.div_dividend;
            core_b           <= div_bus.div_divisor;
            div_bus.div_busy <= 1'b1;
            core_cnt         <= 32;
         end
      end else begin
         if (core_cnt == 1) begin
            div_bus.div_busy <= 1'b0;
            div_bus.div_q    <= core_a / core_b;
            div_bus.div_r    <= core_a % core_b;
         end
         core_cnt <= core_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (div_bus.div_start && !start_prev) start_cnt++;
      start_prev = div_bus.div_start;
   end

   // Reference: MIPS DIV/DIVU with truncating signed division done in 64-bit arithmetic.
   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic clr_ops();
      op_div = 0; op_divu = 0; op_mthi = 0; op_mtlo = 0; op_mfhi = 0; op_mflo = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clr_ops();
      rs_data = '0;
      rt_data = '0;
      #3;
      n_cmp++;
      if ({hi, lo} !== 64'd0 || stall !== 1'b0 || div_bus.div_start !== 1'b0 ||
          div_bus.div_dividend !== 32'd0 || div_bus.div_divisor !== 32'd0) begin
         n_err++;
         $display("FAIL reset_state: hi=%h lo=%h stall=%b start=%b dvd=%h dvs=%h, want all 0",
                  hi, lo, stall, div_bus.div_start, div_bus.div_dividend, div_bus.div_divisor);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input string name);
      logic [63:0] exp;
      int cycles;
      exp = ref_div(sgn, a, b);
      @(posedge clk); #1;
      start_cnt = 0;
      op_div = sgn; op_divu = !sgn; rs_data = a; rt_data = b;
      #1;
      cycles = 0;
      while (stall === 1'b1 && cycles < 45) begin
         @(posedge clk); #1;
         cycles++;
      end
      n_cmp++;
      if ((b == 0 && cycles != 1) || (b != 0 && (cycles < 3 || cycles > 40))) begin
         n_err++;
         $display("FAIL %s_stall_len: got %0d cycles, want %s", name, cycles,
                  (b == 0) ? "1" : "3..40");
      end
      hi_exp = exp[63:32];
      lo_exp = exp[31:0];
      n_cmp++;
      if (hi !== hi_exp || lo !== lo_exp) begin
         n_err++;
         $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, hi_exp, lo_exp);
      end
      // Divide still held across the DONE edge; it must retire, not relaunch.
      @(posedge clk); #1;
      clr_ops();
      #1;
      n_cmp++;
      if (stall !== 1'b0 || hi !== hi_exp || lo !== lo_exp) begin
         n_err++;
         $display("FAIL %s_retire: stall=%b hi=%h lo=%h, want stall=0 hi=%h lo=%h",
                  name, stall, hi, lo, hi_exp, lo_exp);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (start_cnt != ((b != 0) ? 1 : 0)) begin
         n_err++;
         $display("FAIL %s_start_count: got %0d, want %0d", name, start_cnt, (b != 0) ? 1 : 0);
      end
   endtask

   task automatic test_mt(input logic [31:0] hv, input logic [31:0] lv);
      @(posedge clk); #1;
      op_mthi = 1; rs_data = hv;
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_err++;
         $display("FAIL mthi_stall: got %b, want 0", stall);
      end
      @(posedge clk); #1;
      op_mthi = 0; op_mtlo = 1; rs_data = lv;
      hi_exp = hv;
      n_cmp++;
      if (hi !== hi_exp || lo !== lo_exp) begin
         n_err++;
         $display("FAIL mthi_write: hi=%h lo=%h, want hi=%h lo=%h", hi, lo, hi_exp, lo_exp);
      end
      @(posedge clk); #1;
      op_mtlo = 0;
      lo_exp = lv;
      n_cmp++;
      if (hi !== hi_exp || lo !== lo_exp || stall !== 1'b0) begin
         n_err++;
         $display("FAIL mtlo_write: hi=%h lo=%h stall=%b, want hi=%h lo=%h stall=0",
                  hi, lo, stall, hi_exp, lo_exp);
      end
   endtask

   task automatic test_mfhi_during_wait();
      logic [63:0] exp;
      int cycles;
      exp = ref_div(1'b1, 32'hFFFF_FC18, 32'd7);
      @(posedge clk); #1;
      op_div = 1; rs_data = 32'hFFFF_FC18; rt_data = 32'd7;
      repeat (4) begin @(posedge clk); #1; end
      op_div = 0; op_mfhi = 1;
      #1;
      cycles = 4;
      while (stall === 1'b1 && cycles < 45) begin
         @(posedge clk); #1;
         cycles++;
      end
      hi_exp = exp[63:32];
      lo_exp = exp[31:0];
      n_cmp++;
      if (cycles > 40 || cycles < 6 || hi !== hi_exp || lo !== lo_exp) begin
         n_err++;
         $display("FAIL mfhi_wait: cycles=%0d hi=%h lo=%h, want <=40 hi=%h lo=%h",
                  cycles, hi, lo, hi_exp, lo_exp);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_err++;
         $display("FAIL mfhi_idle_stall: got %b, want 0", stall);
      end
      clr_ops();
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      start_cnt = 0;
      op_divu = 1; rs_data = 32'd1000; rt_data = 32'd3;
      repeat (6) begin @(posedge clk); #1; end
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++;
         $display("FAIL rst_wait_stall: got %b, want 1", stall);
      end
      reset = 1'b1;
      clr_ops();
      #1;
      hi_exp = '0;
      lo_exp = '0;
      n_cmp++;
      if (hi !== 32'd0 || lo !== 32'd0 || div_bus.div_start !== 1'b0) begin
         n_err++;
         $display("FAIL rst_wait_clear: hi=%h lo=%h start=%b, want 0 0 0",
                  hi, lo, div_bus.div_start);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (40) begin @(posedge clk); #1; end
      n_cmp++;
      if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || start_cnt != 1) begin
         n_err++;
         $display("FAIL rst_wait_abort: stall=%b hi=%h lo=%h starts=%0d, want 0 0 0 1",
                  stall, hi, lo, start_cnt);
      end
      run_div(1'b0, 32'd9, 32'd3, "post_reset_divu");
   endtask

   task automatic test_random(input int n);
      bit sgn;
      logic [31:0] a, b;
      for (int i = 0; i < n; i++) begin
         sgn = 1'($urandom_range(1, 0));
         a = $urandom;
         case ($urandom_range(3, 0))
            0: b = 32'd0;
            1: b = 32'($urandom_range(15, 1));
            2: b = 32'd0 - 32'($urandom_range(15, 1));
            default: b = $urandom;
         endcase
         if ($urandom_range(3, 0) == 0) test_mt($urandom, $urandom);
         run_div(sgn, a, b, "rand");
      end
   endtask

   initial begin
      test_reset();
      run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
      run_div(1'b1, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
      run_div(1'b1, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
      run_div(1'b0, 32'h0000_1234, 32'd0, "divu_zero");
      run_div(1'b1, 32'hFFFF_0000, 32'd0, "div_zero");
      test_mt(32'h0000_AAAA, 32'h0000_5555);
      test_mfhi_during_wait();
      test_reset_in_wait();
      test_random(12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Controls HI/LO for the MIPS54 CPU; sits between decode/execute and the iterative unsigned divide core.
- Latches DIV/DIVU operands and converts signed operands to magnitudes. Drives the core's dividend/divisor/start, waits on its busy, then sign-corrects q/r into LO/HI.
- Handles MTHI/MTLO and stalls the pipeline on any HI/LO access while a divide is in flight.

Parameters:
- WIDTH, 32, datapath width (only 32 supported).
- DIVZERO_LO, 32'hFFFF_FFFF, value written to LO on divide-by-zero.

Ports:
- clk  in  1  system clock; this block uses posedge. The core uses negedge.
- reset  in  1  reset, asynchronous, active-high (shared with divide core)
- op_div  in  1  signed divide request (held by CPU while stall=1)
- op_divu  in  1  unsigned divide request
- op_mthi  in  1  write rs_data to HI
- op_mtlo  in  1  write rs_data to LO
- op_mfhi  in  1  HI read request (stall qualifier only)
- op_mflo  in  1  LO read request (stall qualifier only)
- rs_data  in  32  dividend / MT source
- rt_data  in  32  divisor
- hi  out  32  HI register
- lo  out  32  LO register
- stall  out  1  combinational; CPU freezes PC and instruction while high
- div_dividend  out  32  magnitude dividend to core (registered)
- div_divisor  out  32  magnitude divisor to core (registered)
- div_start  out  1  start to core (registered)
- div_q  in  32  core quotient
- div_r  in  32  core remainder
- div_busy  in  1  core busy

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, div_start=0, div_dividend=0, div_divisor=0, sign flags=0. Reset mid-divide aborts with no HI/LO write.
- FSM states: IDLE, LAUNCH, WAIT, DONE. At most one op_* is high per cycle. Behaviour with more than one high is unspecified.
- IDLE, op_div|op_divu, rt_data!=0:
  - Latch div_dividend=|rs|, div_divisor=|rt|. Magnitudes apply for op_div only; op_divu passes raw values.
  - Latch q_neg=op_div&(rs[31]^rt[31]) and r_neg=op_div&rs[31].
  - Set div_start=1; go to LAUNCH. stall=1 this cycle.
- IDLE, divide with rt_data==0: go straight to DONE; write hi=rs_data, lo=DIVZERO_LO on this edge; core not started. stall=1 this cycle.
- IDLE, op_mthi/op_mtlo: write on this posedge. No stall; stay in IDLE.
- LAUNCH: stall=1. Hold div_start=1 until div_busy sampled 1. Then clear div_start and go to WAIT.
- WAIT: stall=1. When div_busy is sampled 0:
  - lo = q_neg ? -div_q : div_q
  - hi = r_neg ? -div_r : div_r
  - Go to DONE.
- DONE: stall=0. The held divide instruction retires this cycle, and op_div/op_divu is ignored so the divide is not relaunched. Next state is IDLE. An op_mthi/op_mtlo in DONE is ignored, since the retiring instruction is the divide.
- stall = (state==IDLE & (op_div|op_divu)) | state==LAUNCH | state==WAIT. MF*/MT* requests arriving in non-IDLE states are held by the CPU under stall.
- Overflow 0x8000_0000 / -1 (DIV): magnitudes 0x8000_0000 and 1 give lo=0x8000_0000, hi=0. No trap.
- Negation is two's complement modulo 2^32. Magnitude of 0x8000_0000 is 0x8000_0000.
- Latency: the core needs 1 load negedge plus 32 iteration negedges. Total stall for a nonzero divide is ≤36 cycles; the bench bound is 40.

Decomposition:
- Package hilo_div_pkg:
  - state enum (IDLE, LAUNCH, WAIT, DONE)
  - WIDTH constant
  - DIVZERO_LO default
- Sub-module div_sign_fixup (combinational):
  - abs of rs/rt with op_div qualifier, producing the sign flags
  - conditional negate of q/r
- The FSM and HI/LO registers stay in hilo_div_ctrl.

Test Plan:
- DIVU rs=100, rt=7 → stall high ≤40 cycles, then lo=14, hi=2; stall low exactly one cycle in DONE and no second div_start.
- DIV rs=-100 (0xFFFF_FF9C), rt=7 → lo=0xFFFF_FFF2 (-14), hi=0xFFFF_FFFE (-2); rs=100, rt=-7 → lo=-14, hi=2.
- DIV rs=0x8000_0000, rt=0xFFFF_FFFF → lo=0x8000_0000, hi=0; DIVU same operands → lo=0, hi=0x8000_0000.
- DIVU rt=0, rs=0x1234 → one stall cycle, hi=0x1234, lo=0xFFFF_FFFF, div_start never asserted.
- MTHI 0xAAAA then MTLO 0x5555 with no divide → hi/lo updated on the same edge, stall=0; MFHI issued during WAIT → stall held until DONE, then hi shows the divide result.
- Assert reset in WAIT → state IDLE, hi=lo=0, div_start=0, stall=0 next cycle; a fresh DIVU 9/3 afterwards → lo=3, hi=0.
